// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle control FSM for the non-pipelined MIPS core.
// Sequences fetch/decode/execute/memory/writeback over one shared memory port.
module mips_multicycle_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       memto_reg,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_RWB,
    S_ADDR,
    S_MEM_RD,
    S_LWB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT,
    S_ERROR
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_st;
  logic       done;

  assign mem_st = (state == S_FETCH) ||
                  (state == S_MEM_RD) ||
                  (state == S_MEM_WR);

  // States that complete an instruction this cycle
  assign done = (state == S_RWB) ||
                (state == S_LWB) ||
                (state == S_BRANCH) ||
                (state == S_JUMP) ||
                ((state == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      wait_cnt      <= '0;
      err_code      <= 2'b00;
      instr_retired <= '0;
    end else begin
      if (mem_st && !mem_ready) begin
        if (wait_cnt == WAIT_LAST) begin
          wait_cnt <= '0;
          state    <= S_ERROR;
          err_code <= 2'b01;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else begin
        wait_cnt <= '0;
      end

      if (done) begin
        state         <= halt_req ? S_HALT : S_FETCH;
        instr_retired <= instr_retired + 1'b1;
      end else begin
        unique case (state)
          S_FETCH:  if (mem_ready) state <= S_DECODE;
          S_DECODE: begin
            unique case (opcode)
              OP_R:          state <= S_EXEC_R;
              OP_LW, OP_SW:  state <= S_ADDR;
              OP_BEQ:        state <= S_BRANCH;
              OP_J, OP_JAL:  state <= S_JUMP;
              default: begin
                state    <= S_ERROR;
                err_code <= 2'b10;
              end
            endcase
          end
          S_EXEC_R: state <= S_RWB;
          S_ADDR:   state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
          S_MEM_RD: if (mem_ready) state <= S_LWB;
          S_HALT:   if (!halt_req) state <= S_FETCH;
          default:  ;
        endcase
      end
    end
  end

  logic mem_we_d, ir_write_d, pc_write_d, reg_write_d;

  always_comb begin
    mem_req     = 1'b0;
    mem_we_d    = 1'b0;
    i_or_d      = 1'b0;
    ir_write_d  = 1'b0;
    pc_write_d  = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    reg_write_d = 1'b0;
    reg_dst     = 2'b00;
    memto_reg   = 2'b00;
    halted      = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_d = mem_ready;
        pc_write_d = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write_d = 1'b1;
        reg_dst     = 2'b01;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_LWB: begin
        reg_write_d = 1'b1;
        memto_reg   = 2'b01;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we_d = 1'b1;
        i_or_d   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_write_d = zero;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write_d = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write_d = 1'b1;
          reg_dst     = 2'b10;
          memto_reg   = 2'b10;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // No architectural write may land while reset is asserted
  assign mem_we    = mem_we_d    & ~reset;
  assign ir_write  = ir_write_d  & ~reset;
  assign pc_write  = pc_write_d  & ~reset;
  assign reg_write = reg_write_d & ~reset;

endmodule
